// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HILO full-write port.
// Shift-add multiply, restoring divide, sign fixup at the end; fixed latency.
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [1:0]  hilo_mode,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] ma_q, ma_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        nq_q, nq_d;
  logic        nr_q, nr_d;
  logic        dz_q, dz_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic        is_div;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div = op_q[1];
  assign sgn    = ~op_q[0];

  assign mag_a = (sgn && a_q[31]) ? -a_q : a_q;
  assign mag_b = (sgn && b_q[31]) ? -b_q : b_q;

  // One multiply step: conditionally add the multiplicand, shift right.
  assign mul_sum  = {1'b0, acc_q[63:32]}
                  + {1'b0, (acc_q[0] ? ma_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring-divide step on the shifted {rem,quo} pair.
  assign div_ge   = acc_q[63:31] >= {1'b0, b_q};
  assign div_sub  = acc_q[62:31] - b_q;
  assign div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};

  assign prod_fix = nq_q ? -acc_q : acc_q;
  assign quo_fix  = nq_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = nr_q ? -acc_q[63:32] : acc_q[63:32];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      ma_q     <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      dz_q     <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nq_q     <= nq_d;
      nr_q     <= nr_d;
      dz_q     <= dz_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Next-state and datapath update; flush overrides every busy state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    dz_d     = dz_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
        end
      end
      S_PREP: begin
        ma_d    = mag_a;
        b_d     = mag_b;
        nq_d    = sgn & (a_q[31] ^ b_q[31]);
        nr_d    = sgn & a_q[31];
        dz_d    = is_div & (b_q == 32'd0);
        acc_d   = is_div ? {32'd0, mag_a} : {32'd0, mag_b};
        cnt_d   = 5'd0;
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!is_div) begin
          res_hi_d = prod_fix[63:32];
          res_lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          res_hi_d = a_q;
          res_lo_d = 32'hFFFF_FFFF;
        end else begin
          res_hi_d = rem_fix;
          res_lo_d = quo_fix;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
  end

  assign busy      = (state_q == S_PREP) || (state_q == S_CALC)
                  || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign hilo_mode = {done, done};
  assign stall     = start | busy;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed table, hand-written flush/reset/start-poke
// sequences, and random operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [1:0]  hilo_mode;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hilo_mode (hilo_mode),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o == 2'b00) return 64'(sa * sb);
    if (o == 2'b01) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int poke);
    int n;
    int bcnt;
    bit seen;
    @(negedge clk);
    op = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    #1 chk({nm, " stall"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1 n++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
      if (n == poke) begin
        op = o ^ 2'b01;
        src_a = ~a;
        src_b = b ^ 32'h5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({nm, " latency"}, 64'(n + 1), 64'd35);
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'd34);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, " hilo_mode"}, 64'(hilo_mode), 64'd3);
    chk({nm, " result"}, {res_hi, res_lo}, exp);
    @(posedge clk);
    #1 chk({nm, " done_1cyc"}, {62'd0, hilo_mode}, 64'd0);
    chk({nm, " done_low"}, 64'(done), 64'd0);
    chk({nm, " hold"}, {res_hi, res_lo}, exp);
  endtask

  task automatic watch_no_done(input string nm, input int cyc,
                               input logic [63:0] hold);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1 if (done || hilo_mode != 2'b00) pulses++;
    end
    chk({nm, " no_done"}, 64'(pulses), 64'd0);
    chk({nm, " res_kept"}, {res_hi, res_lo}, hold);
  endtask

  vec_t vecs[12];

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] last;

    vecs[0]  = '{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{"mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
                 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2]  = '{"div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{"divu_7d2", 2'b11, 32'd7, 32'd2,
                 64'h0000_0001_0000_0003};
    vecs[4]  = '{"divu_by0", 2'b11, 32'h64, 32'd0,
                 64'h0000_0064_FFFF_FFFF};
    vecs[5]  = '{"div_by0", 2'b10, 32'hFFFF_FF9C, 32'd0,
                 64'hFFFF_FF9C_FFFF_FFFF};
    vecs[6]  = '{"div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                 64'h0000_0000_8000_0000};
    vecs[7]  = '{"mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000,
                 64'h4000_0000_0000_0000};
    vecs[8]  = '{"mult_zero", 2'b00, 32'd0, 32'h1234_5678,
                 64'd0};
    vecs[9]  = '{"divu_small", 2'b11, 32'd5, 32'd7,
                 64'h0000_0005_0000_0000};
    vecs[10] = '{"div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                 64'h0000_0001_FFFF_FFFD};
    vecs[11] = '{"mult_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'h0000_0000_0000_0001};

    resetn = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hilo_mode", 64'(hilo_mode), 64'd0);
    chk("rst res", {res_hi, res_lo}, 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, -1);
    last = vecs[11].exp;

    // start pulse with other operands while busy is ignored
    run_op("poke", 2'b00, 32'hFFFF_FFFD, 32'h7,
           64'hFFFF_FFFF_FFFF_FFEB, 5);
    last = 64'hFFFF_FFFF_FFFF_FFEB;

    // flush ten cycles into an operation
    @(negedge clk);
    op = 2'b01;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush stall", 64'(stall), 64'd0);
    watch_no_done("flush", 40, last);
    run_op("after_flush", 2'b11, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, -1);
    last = 64'h0000_0002_0000_000E;

    // flush together with start in IDLE
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    chk("flush_start busy", 64'(busy), 64'd0);

    // reset twenty cycles into an operation
    @(negedge clk);
    op = 2'b00;
    src_a = 32'h55;
    src_b = 32'h66;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hilo", 64'(hilo_mode), 64'd0);
    chk("midrst res", {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    watch_no_done("midrst", 40, 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      run_op("rand", ro, ra, rb, model(ro, ra, rb), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
